irq_controller: RTL and testbench

Memory-mapped interrupt controller that collects interrupt requests from the I/O devices on the data bus (keys, switches, timer) and shares the single processor interrupt line between them. It latches request edges into a pending register, applies a software mask and selects the lowest-index enabled source with fixed priority. It then sequences a request / acknowledge / end-of-interrupt handshake with the CPU. It sits on the same memAddr/dataBus as the device registers and is read and written through loads and stores.

---
 rtl/irq_controller.sv | 135 +++++++++++++
 tb/tb_irq_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge capture, mask, fixed priority,
// and a request / acknowledge / end-of-interrupt handshake with the CPU.
module irq_controller #(
  parameter int              BITS    = 32,
  parameter int              NUM_SRC = 4,
  parameter logic [BITS-1:0] BASE    = 32'hF0000100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic               re,
  input  logic [BITS-1:0]    memAddr,
  input  logic [BITS-1:0]    dataBusIn,
  input  logic [NUM_SRC-1:0] irqIn,
  input  logic               intAck,
  output logic               intr,
  output logic [BITS-1:0]    dataBusOut
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERV
  } state_t;

  localparam logic [BITS-1:0] A_PEND = BASE;
  localparam logic [BITS-1:0] A_MASK = BASE + BITS'(4);
  localparam logic [BITS-1:0] A_ID   = BASE + BITS'(8);
  localparam logic [BITS-1:0] A_EOI  = BASE + BITS'(12);
  localparam logic [BITS-1:0] A_OVR  = BASE + BITS'(16);

  state_t             state, state_n;
  logic [NUM_SRC-1:0] pend, pend_n;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] ovr, ovr_n;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] rise, elig;
  logic [NUM_SRC-1:0] ack_clr, pend_clr, ovr_clr;
  logic [3:0]         cur_src, cur_n, lo_idx;
  logic               cur_elig, any_elig, ack;
  logic               rd, valid;
  logic               hit_pend, hit_mask, hit_id, hit_eoi, hit_ovr;
  logic               unused;

  assign unused = ^dataBusIn;

  assign hit_pend = memAddr == A_PEND;
  assign hit_mask = memAddr == A_MASK;
  assign hit_id   = memAddr == A_ID;
  assign hit_eoi  = memAddr == A_EOI;
  assign hit_ovr  = memAddr == A_OVR;
  assign rd       = re & ~we;

  assign rise     = irqIn & ~irq_prev;
  assign elig     = pend & mask;
  assign any_elig = |elig;
  assign ack      = (state == REQ) & intAck;
  assign valid    = (state == REQ) | (state == SERV);

  assign pend_clr = (we & hit_pend) ? dataBusIn[NUM_SRC-1:0] : '0;
  assign ovr_clr  = (we & hit_ovr) ? dataBusIn[NUM_SRC-1:0] : '0;

  always_comb begin
    lo_idx   = '0;
    cur_elig = 1'b0;
    ack_clr  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) lo_idx = 4'(i);
      if (cur_src == 4'(i)) begin
        cur_elig   = elig[i];
        ack_clr[i] = ack;
      end
    end
  end

  // Sets take priority over any clear landing in the same cycle.
  assign pend_n = (pend & ~pend_clr & ~ack_clr) | rise;
  assign ovr_n  = (ovr & ~ovr_clr) | (rise & pend);

  always_comb begin
    state_n = state;
    cur_n   = cur_src;
    case (state)
      IDLE: begin
        if (any_elig) begin
          cur_n   = lo_idx;
          state_n = REQ;
        end
      end
      REQ: begin
        if (intAck)         state_n = SERV;
        else if (!cur_elig) state_n = IDLE;
      end
      SERV: begin
        if (we && hit_eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      pend     <= '0;
      mask     <= '0;
      ovr      <= '0;
      irq_prev <= '0;
      cur_src  <= '0;
      intr     <= 1'b0;
    end else begin
      state    <= state_n;
      pend     <= pend_n;
      ovr      <= ovr_n;
      irq_prev <= irqIn;
      cur_src  <= cur_n;
      intr     <= state_n == REQ;
      if (we && hit_mask) mask <= dataBusIn[NUM_SRC-1:0];
    end
  end

  always_comb begin
    dataBusOut = '0;
    if (rd) begin
      unique case (1'b1)
        hit_pend: dataBusOut = {{(BITS-NUM_SRC){1'b0}}, pend};
        hit_mask: dataBusOut = {{(BITS-NUM_SRC){1'b0}}, mask};
        hit_id:   dataBusOut = {valid, {(BITS-5){1'b0}},
                                (valid ? cur_src : 4'd0)};
        hit_ovr:  dataBusOut = {{(BITS-NUM_SRC){1'b0}}, ovr};
        default:  dataBusOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed-vector bench for irq_controller.
module tb_irq_controller;

  localparam logic [31:0] A_PEND = 32'hF000_0100;
  localparam logic [31:0] A_MASK = 32'hF000_0104;
  localparam logic [31:0] A_ID   = 32'hF000_0108;
  localparam logic [31:0] A_EOI  = 32'hF000_010C;
  localparam logic [31:0] A_OVR  = 32'hF000_0110;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, re;
  logic [31:0] memAddr, dataBusIn;
  logic [3:0]  irqIn;
  logic        intAck;
  logic        intr;
  logic [31:0] dataBusOut;

  int vectors = 0;
  int miscompares = 0;

  irq_controller dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .re(re),
    .memAddr(memAddr),
    .dataBusIn(dataBusIn),
    .irqIn(irqIn),
    .intAck(intAck),
    .intr(intr),
    .dataBusOut(dataBusOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string tag);
    re = 1'b1;
    memAddr = a;
    #1;
    check(tag, dataBusOut, exp);
    re = 1'b0;
    memAddr = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1;
    memAddr = a;
    dataBusIn = d;
    tick();
    we = 1'b0;
    memAddr = '0;
    dataBusIn = '0;
  endtask

  task automatic ack();
    intAck = 1'b1;
    tick();
    intAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; we = 1'b0; re = 1'b0; memAddr = '0;
    dataBusIn = '0; irqIn = 4'hF; intAck = 1'b0;
    #1;
    repeat (3) tick();
    rd(A_PEND, 32'h0, "rst_pend");
    rd(A_MASK, 32'h0, "rst_mask");
    rd(A_OVR, 32'h0, "rst_ovr");
    check("rst_intr", 32'(intr), 32'h0);
    check("idle_bus", dataBusOut, 32'h0);

    reset = 1'b1; irqIn = 4'h0;
    tick();
    irqIn = 4'h1;
    tick();
    tick();
    rd(A_PEND, 32'h1, "masked_pend");
    check("masked_intr", 32'(intr), 32'h0);
    wr(A_PEND, 32'hF);
    rd(A_PEND, 32'h0, "w1c_pend");
    irqIn = 4'h0;
    tick();

    // Basic handshake on source 2
    wr(A_MASK, 32'h4);
    rd(A_MASK, 32'h4, "mask_rd");
    irqIn = 4'h4;
    tick();
    check("lat_k", 32'(intr), 32'h0);
    tick();
    check("lat_k1", 32'(intr), 32'h1);
    rd(A_ID, 32'h8000_0002, "id_req");
    ack();
    check("ack_intr", 32'(intr), 32'h0);
    rd(A_PEND, 32'h0, "ack_pend");
    rd(A_ID, 32'h8000_0002, "id_serv");
    rd(A_EOI, 32'h0, "eoi_rd");
    wr(A_EOI, 32'h0);
    rd(A_ID, 32'h0, "id_eoi");
    irqIn = 4'h0;
    tick();

    // Priority: sources 3 and 1 together
    wr(A_MASK, 32'hF);
    irqIn = 4'hA;
    tick();
    tick();
    check("pri_intr", 32'(intr), 32'h1);
    rd(A_ID, 32'h8000_0001, "pri_id1");
    ack();
    rd(A_PEND, 32'h8, "pri_pend");
    tick();
    check("serv_hold", 32'(intr), 32'h0);
    wr(A_EOI, 32'h0);
    check("eoi_e", 32'(intr), 32'h0);
    tick();
    check("eoi_e1", 32'(intr), 32'h1);
    rd(A_ID, 32'h8000_0003, "pri_id3");
    ack();
    wr(A_EOI, 32'h0);
    irqIn = 4'h0;
    tick();
    check("pri_done", 32'(intr), 32'h0);

    // Withdraw by software clear
    irqIn = 4'h1;
    tick();
    tick();
    check("wd_req", 32'(intr), 32'h1);
    wr(A_PEND, 32'h1);
    tick();
    check("wd_intr", 32'(intr), 32'h0);
    rd(A_ID, 32'h0, "wd_id");
    ack();
    rd(A_PEND, 32'h0, "wd_pend");
    check("wd_ack_intr", 32'(intr), 32'h0);
    irqIn = 4'h0;
    tick();

    // Overrun and set-wins
    wr(A_MASK, 32'h0);
    irqIn = 4'h2;
    tick();
    irqIn = 4'h0;
    tick();
    irqIn = 4'h2;
    tick();
    rd(A_OVR, 32'h2, "ovr_set");
    rd(A_PEND, 32'h2, "ovr_pend");
    irqIn = 4'h0;
    tick();
    irqIn = 4'h2;
    wr(A_PEND, 32'h2);
    rd(A_PEND, 32'h2, "set_wins");
    wr(A_OVR, 32'h2);
    rd(A_OVR, 32'h0, "ovr_w1c");
    wr(A_PEND, 32'hF);
    rd(A_PEND, 32'h0, "pend_clr");
    irqIn = 4'h0;
    tick();

    // Reset while in service
    wr(A_MASK, 32'hF);
    irqIn = 4'h1;
    tick();
    tick();
    ack();
    rd(A_ID, 32'h8000_0000, "mid_serv");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rd(A_ID, 32'h0, "mid_id");
    rd(A_MASK, 32'h0, "mid_mask");
    wr(A_EOI, 32'h0);
    rd(A_ID, 32'h0, "mid_eoi");
    tick();
    tick();
    check("mid_intr", 32'(intr), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
